// File: rtl/core_mem_access_ctrl.sv
// Data-memory access controller: one load/store at a time over a req/gnt/rvalid bus,
// with byte-lane steering, right-aligned unextended load data and fault/timeout reporting.
module core_mem_access_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_size_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic is_illegal(input logic we, input logic [2:0] size, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (size)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            3'b000, 3'b100: be = 4'b0001 << a;
            3'b001, 3'b101: be = a[1] ? 4'b1100 : 4'b0011;
            3'b010:         be = 4'b1111;
            default:        be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [2:0] size,
                                                         input logic [DATA_WIDTH-1:0] wd);
        logic [DATA_WIDTH-1:0] res;
        res = wd;
        case (size)
            3'b000, 3'b100: res = {4{wd[7:0]}};
            3'b001, 3'b101: res = {2{wd[15:0]}};
            default:        res = wd;
        endcase
        return res;
    endfunction

    // Loads come back shifted down to bit 0 and masked; sign extension happens downstream.
    function automatic logic [DATA_WIDTH-1:0] align_rdata(input logic [2:0] size, input logic [1:0] a,
                                                          input logic [DATA_WIDTH-1:0] rd);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] res;
        sh  = rd >> {a, 3'b000};
        res = sh;
        case (size)
            3'b000, 3'b100: res = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            3'b001, 3'b101: res = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default:        res = sh;
        endcase
        return res;
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_next_s;
    logic                  we_r;
    logic [2:0]            size_r;
    logic [1:0]            addr_lo_r;
    logic                  latch_s;
    logic                  capture_s;
    logic                  fault_s;
    logic                  illegal_in_s;

    logic                  req_ready_r;
    logic                  mem_req_r;
    logic                  mem_we_r;
    logic [3:0]            mem_be_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic                  rsp_err_r;

    assign illegal_in_s = is_illegal(req_we_i, req_size_i, req_addr_i[1:0]);

    // Next-state, timeout counter and response decisions.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        latch_s      = 1'b0;
        capture_s    = 1'b0;
        fault_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) begin
                    latch_s = 1'b1;
                    if (illegal_in_s) begin
                        state_next_s = ST_RESP;
                        fault_s      = 1'b1;
                    end else begin
                        state_next_s = ST_REQ;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    cnt_next_s = {CNT_W{1'b0}};
                    if (we_r) begin
                        state_next_s = ST_RESP;
                    end else if (mem_rvalid_i) begin
                        capture_s    = 1'b1;
                        state_next_s = ST_RESP;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_RESP;
                    fault_s      = 1'b1;
                end else begin
                    cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_RESP;
                    fault_s      = 1'b1;
                end else begin
                    cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and latched request attributes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            we_r      <= 1'b0;
            size_r    <= 3'b000;
            addr_lo_r <= 2'b00;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (latch_s) begin
                we_r      <= req_we_i;
                size_r    <= req_size_i;
                addr_lo_r <= req_addr_i[1:0];
            end
        end
    end

    // Registered bus and response outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready_r <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            req_ready_r <= (state_next_s == ST_IDLE);
            mem_req_r   <= (state_next_s == ST_REQ);
            rsp_valid_r <= (state_next_s == ST_RESP);
            if (latch_s && !illegal_in_s) begin
                mem_we_r    <= req_we_i;
                mem_be_r    <= lane_be(req_size_i, req_addr_i[1:0]);
                mem_addr_r  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata_r <= lane_wdata(req_size_i, req_wdata_i);
            end
            if (state_next_s == ST_RESP) begin
                rsp_err_r   <= fault_s;
                rsp_rdata_r <= capture_s ? align_rdata(size_r, addr_lo_r, mem_rdata_i)
                                         : {DATA_WIDTH{1'b0}};
            end
        end
    end

    assign req_ready_o = req_ready_r;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_be_o    = mem_be_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_core_mem_access_ctrl.sv
// Directed self-checking bench for core_mem_access_ctrl; expected values are hand-computed.
module tb_core_mem_access_ctrl;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_vec = 0;
    int n_err = 0;

    core_mem_access_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        cyc(); cyc();
        check_val("rst_ready", {31'h0, req_ready}, 32'h1);
        check_val("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check_val("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_val("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        rst_n = 1'b1;
        cyc();

        // SB 0x103
        drive_req(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB);
        cyc();
        req_valid = 1'b0;
        check_val("sb_mem_req", {31'h0, mem_req}, 32'h1);
        check_val("sb_ready", {31'h0, req_ready}, 32'h0);
        check_val("sb_we", {31'h0, mem_we}, 32'h1);
        check_val("sb_be", {28'h0, mem_be}, 32'h8);
        check_val("sb_addr", mem_addr, 32'h0000_0100);
        check_val("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        check_val("sb_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check_val("sb_rsp_err", {31'h0, rsp_err}, 32'h0);
        check_val("sb_rsp_rdata", rsp_rdata, 32'h0);
        check_val("sb_req_drop", {31'h0, mem_req}, 32'h0);
        cyc();
        check_val("sb_pulse_end", {31'h0, rsp_valid}, 32'h0);
        check_val("sb_ready_back", {31'h0, req_ready}, 32'h1);

        // LHU 0x202, rvalid one cycle after gnt
        drive_req(1'b0, 3'b101, 32'h0000_0202, 32'h0);
        cyc();
        req_valid = 1'b0;
        check_val("lhu_be", {28'h0, mem_be}, 32'hC);
        check_val("lhu_addr", mem_addr, 32'h0000_0200);
        check_val("lhu_we", {31'h0, mem_we}, 32'h0);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        check_val("lhu_wait_req", {31'h0, mem_req}, 32'h0);
        check_val("lhu_wait_valid", {31'h0, rsp_valid}, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        cyc();
        mem_rvalid = 1'b0;
        check_val("lhu_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check_val("lhu_rdata", rsp_rdata, 32'h0000_1234);
        check_val("lhu_err", {31'h0, rsp_err}, 32'h0);
        cyc();

        // LB 0x13, same-cycle gnt+rvalid
        drive_req(1'b0, 3'b000, 32'h0000_0013, 32'h0);
        cyc();
        req_valid = 1'b0;
        check_val("lb_be", {28'h0, mem_be}, 32'h8);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check_val("lb_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check_val("lb_rdata", rsp_rdata, 32'h0000_00DE);
        cyc();

        // LH 0x2: upper half, no sign extension
        drive_req(1'b0, 3'b001, 32'h0000_0002, 32'h0);
        cyc();
        req_valid = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000;
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check_val("lh_rdata", rsp_rdata, 32'h0000_8001);
        cyc();

        // Illegal: LW 0x6, LH 0x1, SBU
        drive_req(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        cyc();
        req_valid = 1'b0;
        check_val("lw_mis_mem_req", {31'h0, mem_req}, 32'h0);
        check_val("lw_mis_valid", {31'h0, rsp_valid}, 32'h1);
        check_val("lw_mis_err", {31'h0, rsp_err}, 32'h1);
        check_val("lw_mis_rdata", rsp_rdata, 32'h0);
        cyc();
        check_val("lw_mis_err_hold", {31'h0, rsp_err}, 32'h1);
        check_val("lw_mis_pulse_end", {31'h0, rsp_valid}, 32'h0);
        drive_req(1'b0, 3'b001, 32'h0000_0001, 32'h0);
        cyc();
        req_valid = 1'b0;
        check_val("lh_mis_mem_req", {31'h0, mem_req}, 32'h0);
        check_val("lh_mis_valid", {31'h0, rsp_valid}, 32'h1);
        check_val("lh_mis_err", {31'h0, rsp_err}, 32'h1);
        cyc();
        drive_req(1'b1, 3'b100, 32'h0000_0000, 32'h0);
        cyc();
        req_valid = 1'b0;
        check_val("sbu_err", {31'h0, rsp_err}, 32'h1);
        check_val("sbu_mem_req", {31'h0, mem_req}, 32'h0);
        cyc();

        // LB 0x10 with gnt withheld: abort after TO cycles in REQ
        drive_req(1'b0, 3'b000, 32'h0000_0010, 32'h0);
        cyc();
        req_valid = 1'b0;
        check_val("to_be", {28'h0, mem_be}, 32'h1);
        for (int i = 0; i < TO - 1; i++) cyc();
        check_val("to_still_req", {31'h0, mem_req}, 32'h1);
        cyc();
        check_val("to_req_drop", {31'h0, mem_req}, 32'h0);
        check_val("to_valid", {31'h0, rsp_valid}, 32'h1);
        check_val("to_err", {31'h0, rsp_err}, 32'h1);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        cyc();
        check_val("to_late_1", {31'h0, rsp_valid}, 32'h0);
        cyc();
        check_val("to_late_2", {31'h0, rsp_valid}, 32'h0);
        check_val("to_late_req", {31'h0, mem_req}, 32'h0);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        cyc();

        // Reset while in WAIT, then SW 0x20
        drive_req(1'b0, 3'b010, 32'h0000_0030, 32'h0);
        cyc();
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check_val("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        check_val("mid_rst_mem_req", {31'h0, mem_req}, 32'h0);
        check_val("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        cyc();
        mem_rvalid = 1'b0;
        check_val("mid_rst_no_pulse", {31'h0, rsp_valid}, 32'h0);
        drive_req(1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D);
        cyc();
        req_valid = 1'b0;
        check_val("sw_be", {28'h0, mem_be}, 32'hF);
        check_val("sw_wdata", mem_wdata, 32'hCAFE_F00D);
        check_val("sw_addr", mem_addr, 32'h0000_0020);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        check_val("sw_valid", {31'h0, rsp_valid}, 32'h1);
        check_val("sw_err", {31'h0, rsp_err}, 32'h0);
        cyc();

        // Back-to-back LW 0x40, 0x44
        drive_req(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        cyc();
        req_addr = 32'h0000_0044;
        check_val("b2b_ready_1", {31'h0, req_ready}, 32'h0);
        check_val("b2b_addr_1", mem_addr, 32'h0000_0040);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check_val("b2b_valid_1", {31'h0, rsp_valid}, 32'h1);
        check_val("b2b_rdata_1", rsp_rdata, 32'h1111_1111);
        check_val("b2b_ready_resp", {31'h0, req_ready}, 32'h0);
        cyc();
        check_val("b2b_ready_idle", {31'h0, req_ready}, 32'h1);
        check_val("b2b_gap_valid", {31'h0, rsp_valid}, 32'h0);
        cyc();
        req_valid = 1'b0;
        check_val("b2b_ready_2", {31'h0, req_ready}, 32'h0);
        check_val("b2b_addr_2", mem_addr, 32'h0000_0044);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check_val("b2b_valid_2", {31'h0, rsp_valid}, 32'h1);
        check_val("b2b_rdata_2", rsp_rdata, 32'h2222_2222);
        cyc();
        check_val("b2b_end", {31'h0, rsp_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
